// File: rtl/i2c_mem_arbiter.sv
// Arbitrates one single-port byte memory between the I2C read engine (port A)
// and the host bus (port B), with fair alternation, B burst lock and bounded A wait.
module i2c_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 1,
  parameter int A_MAX_WAIT  = 6
) (
  input  logic              in_ext_osc,
  input  logic              in_reset,
  input  logic              in_a_req,
  input  logic [ADDR_W-1:0] in_a_addr,
  output logic              out_a_gnt,
  output logic              out_a_rvalid,
  output logic [DATA_W-1:0] out_a_rdata,
  input  logic              in_b_req,
  input  logic              in_b_we,
  input  logic              in_b_lock,
  input  logic [ADDR_W-1:0] in_b_addr,
  input  logic [DATA_W-1:0] in_b_wdata,
  output logic              out_b_gnt,
  output logic              out_b_rvalid,
  output logic [DATA_W-1:0] out_b_rdata,
  output logic              out_mem_en,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic              out_a_preempt
);

  // state     | meaning
  // S_RR      | round-robin between A and B
  // S_LOCKED  | B owns the memory while in_b_lock stays high
  // S_PREEMPT | one dead cycle after A forced its way through a B lock
  typedef enum logic [1:0] {S_RR = 2'd0, S_LOCKED = 2'd1, S_PREEMPT = 2'd2} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(A_MAX_WAIT);

  state_t                 state;
  logic                   last_b;
  logic [7:0]             wait_cnt;
  logic                   mem_own_b;
  logic [MEM_LATENCY-1:0] pipe_v;
  logic [MEM_LATENCY-1:0] pipe_b;
  logic                   a_elig;
  logic                   b_elig;
  logic                   grant_a;
  logic                   grant_b;
  logic                   fire;
  logic                   to_rr;

  always_comb begin
    a_elig  = in_a_req & ~out_a_gnt;
    b_elig  = in_b_req & ~out_b_gnt;
    grant_a = 1'b0;
    grant_b = 1'b0;
    fire    = 1'b0;
    unique case (state)
      S_RR: begin
        if (a_elig && b_elig) begin
          grant_a = last_b;
          grant_b = ~last_b;
        end else begin
          grant_a = a_elig;
          grant_b = b_elig;
        end
      end
      S_LOCKED: begin
        if (in_b_lock) begin
          // the edge that would make the wait count reach the limit grants A
          if (a_elig && (wait_cnt >= WAIT_MAX - 8'd1)) begin
            grant_a = 1'b1;
            fire    = 1'b1;
          end else begin
            grant_b = b_elig;
          end
        end else begin
          grant_a = a_elig;
          grant_b = b_elig & ~a_elig;
        end
      end
      default: begin
      end
    endcase
    to_rr = (state != S_RR) && !in_b_lock;
  end

  always_ff @(posedge in_ext_osc or posedge in_reset) begin
    if (in_reset) begin
      state         <= S_RR;
      last_b        <= 1'b1;
      wait_cnt      <= '0;
      mem_own_b     <= 1'b0;
      pipe_v        <= '0;
      pipe_b        <= '0;
      out_a_gnt     <= 1'b0;
      out_b_gnt     <= 1'b0;
      out_a_rvalid  <= 1'b0;
      out_b_rvalid  <= 1'b0;
      out_a_rdata   <= '0;
      out_b_rdata   <= '0;
      out_mem_en    <= 1'b0;
      out_mem_we    <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
      out_a_preempt <= 1'b0;
    end else begin
      out_a_gnt  <= grant_a;
      out_b_gnt  <= grant_b;
      out_mem_en <= grant_a | grant_b;
      out_mem_we <= grant_b & in_b_we;
      if (grant_a) begin
        out_mem_addr  <= in_a_addr;
        out_mem_wdata <= '0;
        mem_own_b     <= 1'b0;
      end else if (grant_b) begin
        out_mem_addr  <= in_b_addr;
        out_mem_wdata <= in_b_wdata;
        mem_own_b     <= 1'b1;
      end

      if (grant_a)      last_b <= 1'b0;
      else if (grant_b) last_b <= 1'b1;
      else if (to_rr)   last_b <= 1'b1;

      if (fire) out_a_preempt <= 1'b1;

      if (grant_a || !in_a_req)                wait_cnt <= '0;
      else if (a_elig && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 8'd1;

      unique case (state)
        S_RR:      if (grant_b && in_b_lock) state <= S_LOCKED;
        S_LOCKED:  if (fire) state <= S_PREEMPT;
                   else if (!in_b_lock) state <= S_RR;
        S_PREEMPT: state <= in_b_lock ? S_LOCKED : S_RR;
        default:   state <= S_RR;
      endcase

      // owner tag travels alongside the read until the memory data is due
      pipe_v[0] <= out_mem_en & ~out_mem_we;
      pipe_b[0] <= mem_own_b;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
      out_a_rvalid <= pipe_v[MEM_LATENCY-1] & ~pipe_b[MEM_LATENCY-1];
      out_b_rvalid <= pipe_v[MEM_LATENCY-1] &  pipe_b[MEM_LATENCY-1];
      if (pipe_v[MEM_LATENCY-1]) begin
        if (pipe_b[MEM_LATENCY-1]) out_b_rdata <= in_mem_rdata;
        else                       out_a_rdata <= in_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Directed bench for i2c_mem_arbiter: two instances (read latency 1 and 3) share
// one stimulus; read responses are matched against a queue of expected results.
module tb_i2c_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req, b_req, b_we, b_lock;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  b_wdata;

  logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_en1, mem_we1, pre1;
  logic [7:0]  a_rdata1, b_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;
  logic        a_gnt3, a_rvalid3, b_gnt3, b_rvalid3, mem_en3, mem_we3, pre3;
  logic [7:0]  a_rdata3, b_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0] mem_addr3;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic       port_b;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  i2c_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(1), .A_MAX_WAIT(6)) dut1 (
    .in_ext_osc(clk), .in_reset(rst),
    .in_a_req(a_req), .in_a_addr(a_addr),
    .out_a_gnt(a_gnt1), .out_a_rvalid(a_rvalid1), .out_a_rdata(a_rdata1),
    .in_b_req(b_req), .in_b_we(b_we), .in_b_lock(b_lock),
    .in_b_addr(b_addr), .in_b_wdata(b_wdata),
    .out_b_gnt(b_gnt1), .out_b_rvalid(b_rvalid1), .out_b_rdata(b_rdata1),
    .out_mem_en(mem_en1), .out_mem_we(mem_we1), .out_mem_addr(mem_addr1),
    .out_mem_wdata(mem_wdata1), .in_mem_rdata(mem_rdata1), .out_a_preempt(pre1)
  );

  i2c_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(3), .A_MAX_WAIT(6)) dut3 (
    .in_ext_osc(clk), .in_reset(rst),
    .in_a_req(a_req), .in_a_addr(a_addr),
    .out_a_gnt(a_gnt3), .out_a_rvalid(a_rvalid3), .out_a_rdata(a_rdata3),
    .in_b_req(b_req), .in_b_we(b_we), .in_b_lock(b_lock),
    .in_b_addr(b_addr), .in_b_wdata(b_wdata),
    .out_b_gnt(b_gnt3), .out_b_rvalid(b_rvalid3), .out_b_rdata(b_rdata3),
    .out_mem_en(mem_en3), .out_mem_we(mem_we3), .out_mem_addr(mem_addr3),
    .out_mem_wdata(mem_wdata3), .in_mem_rdata(mem_rdata3), .out_a_preempt(pre3)
  );

  // unwritten locations read back as a fixed pattern; pat(1) = 8'h5A
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5B;
  endfunction

  logic [7:0] mem1 [int];
  logic [7:0] mem3 [int];
  logic [7:0] r3 [3];

  always @(posedge clk) begin
    if (mem_en1 && mem_we1) mem1[int'(mem_addr1)] = mem_wdata1;
    else if (mem_en1)
      mem_rdata1 <= mem1.exists(int'(mem_addr1)) ? mem1[int'(mem_addr1)] : pat(mem_addr1);
  end

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) mem3[int'(mem_addr3)] = mem_wdata3;
    r3[0] <= (mem_en3 && !mem_we3) ?
             (mem3.exists(int'(mem_addr3)) ? mem3[int'(mem_addr3)] : pat(mem_addr3)) : 8'h00;
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign mem_rdata3 = r3[2];

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gnt_chk(input string tag, input logic ea, input logic eb);
    check({tag, "_a_gnt"}, 32'(a_gnt1), 32'(ea));
    check({tag, "_b_gnt"}, 32'(b_gnt1), 32'(eb));
    check({tag, "_mem_en"}, 32'(mem_en1), 32'(ea | eb));
  endtask

  task automatic expect_read(input logic pb, input logic [7:0] d, input int g);
    q1.push_back('{port_b: pb, data: d, due: g + 2});
    q3.push_back('{port_b: pb, data: d, due: g + 4});
  endtask

  task automatic resp_check(input int d, input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd);
    exp_t e;
    int   sz;
    if (!(av || bv)) return;
    check($sformatf("rv_both_l%0d", d), 32'(av & bv), 32'd0);
    sz = (d == 1) ? q1.size() : q3.size();
    check($sformatf("rv_expected_l%0d", d), 32'(sz != 0), 32'd1);
    if (sz == 0) return;
    if (d == 1) e = q1.pop_front();
    else        e = q3.pop_front();
    check($sformatf("rv_port_l%0d", d), 32'(bv), 32'(e.port_b));
    check($sformatf("rv_data_l%0d", d), 32'(bv ? bd : ad), 32'(e.data));
    check($sformatf("rv_cycle_l%0d", d), 32'(cyc), 32'(e.due));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_mutex", 32'(a_gnt1 & b_gnt1), 32'd0);
      resp_check(1, a_rvalid1, a_rdata1, b_rvalid1, b_rdata1);
      resp_check(3, a_rvalid3, a_rdata3, b_rvalid3, b_rdata3);
    end
  end

  initial begin
    logic ea, eb;
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
    b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 32'({a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_en1, mem_we1, pre1}), 32'd0);
    check("rst_data", 32'({a_rdata1, b_rdata1, mem_wdata1}), 32'd0);
    check("rst_addr", 32'(mem_addr1), 32'd0);
    rst = 1'b0;

    // lone A read of mem[1]
    a_req = 1'b1; a_addr = 16'h0001;
    step();
    gnt_chk("t1_c1", 1'b1, 1'b0);
    check("t1_we_c1", 32'(mem_we1), 32'd0);
    check("t1_addr", 32'(mem_addr1), 32'h0001);
    expect_read(1'b0, 8'h5A, cyc);
    a_req = 1'b0;
    step();
    gnt_chk("t1_c2", 1'b0, 1'b0);
    check("t1_we_c2", 32'(mem_we1), 32'd0);
    repeat (5) step();

    // B write, then A reads it back
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'hAACC; b_wdata = 8'h33;
    step();
    gnt_chk("t3_wr", 1'b0, 1'b1);
    check("t3_wr_we", 32'(mem_we1), 32'd1);
    check("t3_wr_addr", 32'(mem_addr1), 32'hAACC);
    check("t3_wr_data", 32'(mem_wdata1), 32'h33);
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_addr = 16'hAACC;
    step();
    gnt_chk("t3_rd", 1'b1, 1'b0);
    check("t3_rd_we", 32'(mem_we1), 32'd0);
    check("t3_rd_addr", 32'(mem_addr1), 32'hAACC);
    expect_read(1'b0, 8'h33, cyc);
    a_req = 1'b0;
    repeat (5) step();

    // two reads in flight, then reset; A won last so B wins this tie
    a_req = 1'b1; a_addr = 16'h0010; b_req = 1'b1; b_addr = 16'h0020;
    step();
    gnt_chk("t6_b", 1'b0, 1'b1);
    b_req = 1'b0;
    step();
    gnt_chk("t6_a", 1'b1, 1'b0);
    a_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ctl", 32'({a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_en1, mem_we1, pre1}), 32'd0);
    check("t6_rst_data", 32'({a_rdata1, b_rdata1, mem_wdata1}), 32'd0);
    check("t6_rst_addr", 32'(mem_addr1), 32'd0);
    check("t6_rst_l3", 32'({a_gnt3, b_gnt3, mem_en3, a_rvalid3, b_rvalid3}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // continuous reads from both ports alternate, A first after reset
    a_req = 1'b1; a_addr = 16'h0100; b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 1) begin
        gnt_chk($sformatf("t2_k%0d", k), 1'b1, 1'b0);
        check("t2_addr_a", 32'(mem_addr1), 32'(a_addr));
        expect_read(1'b0, pat(a_addr), cyc);
        a_addr = a_addr + 16'd1;
      end else begin
        gnt_chk($sformatf("t2_k%0d", k), 1'b0, 1'b1);
        check("t2_addr_b", 32'(mem_addr1), 32'(b_addr));
        expect_read(1'b1, pat(b_addr), cyc);
        b_addr = b_addr + 16'd1;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) step();

    // B locks with back-to-back writes; A arrives at cycle 15 and preempts at 21
    b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 16'h0300;
    for (int c = 13; c <= 25; c++) begin
      step();
      ea = (c == 21);
      eb = (c == 13) || (c == 15) || (c == 17) || (c == 19) || (c == 23) || (c == 25);
      gnt_chk($sformatf("t4_c%0d", c), ea, eb);
      check($sformatf("t4_pre_c%0d", c), 32'(pre1), 32'(c >= 21));
      check($sformatf("t4_we_c%0d", c), 32'(mem_we1), 32'(eb));
      if (ea) begin
        check("t4_a_addr", 32'(mem_addr1), 32'h0005);
        expect_read(1'b0, pat(16'h0005), cyc);
        a_req = 1'b0;
      end
      if (c == 15) begin
        a_req = 1'b1; a_addr = 16'h0005;
      end
      b_wdata = 8'(c);
    end

    // lock released: back to round-robin, A wins the next tie
    b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0;
    step();
    gnt_chk("t4_rel", 1'b0, 1'b0);
    a_req = 1'b1; a_addr = 16'h0006; b_req = 1'b1; b_addr = 16'h0007;
    step();
    gnt_chk("rr_tie", 1'b1, 1'b0);
    expect_read(1'b0, pat(16'h0006), cyc);
    a_req = 1'b0;
    step();
    gnt_chk("rr_b", 1'b0, 1'b1);
    expect_read(1'b1, pat(16'h0007), cyc);
    b_req = 1'b0;
    check("pre_sticky", 32'(pre1), 32'd1);
    repeat (6) step();

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_mem_arbiter.md
Name: i2c_mem_arbiter

Overview:
- Arbitrates a single-port byte memory between two requesters. Port A is the I2C slave byte engine and is read-only. Port B is the local host bus and can read and write.
- Sits between the I2C slave core and the memory instance in the I2C slave top.
- Uses fair alternation by default. Port B may lock the memory for bursts. A bounded-wait override guarantees Port A is served in time to return SDA data within one SCL phase.

Parameters:
- ADDR_W, 16, memory address width (byte offset, matches the 2-byte I2C pointer).
- DATA_W, 8, data width.
- MEM_LATENCY, 1, memory read latency in cycles; legal range 1..4.
- A_MAX_WAIT, 6, cycles Port A may stay pending before it forcibly preempts a B lock; legal range 2..255.

Ports:
- in_ext_osc  input  1  clock.
- in_reset  input  1  asynchronous, active-high reset.
- in_a_req  input  1  Port A read request; held until out_a_gnt.
- in_a_addr  input  ADDR_W  Port A address.
- out_a_gnt  output  1  one-cycle grant pulse to Port A.
- out_a_rvalid  output  1  one-cycle pulse; out_a_rdata is valid.
- out_a_rdata  output  DATA_W  Port A read data.
- in_b_req  input  1  Port B request; held until out_b_gnt.
- in_b_we  input  1  1 = write, 0 = read.
- in_b_lock  input  1  requests exclusive ownership while high.
- in_b_addr  input  ADDR_W  Port B address.
- in_b_wdata  input  DATA_W  Port B write data.
- out_b_gnt  output  1  one-cycle grant pulse to Port B.
- out_b_rvalid  output  1  one-cycle read-data pulse.
- out_b_rdata  output  DATA_W  Port B read data.
- out_mem_en  output  1  memory access strobe.
- out_mem_we  output  1  memory write enable.
- out_mem_addr  output  ADDR_W  memory address.
- out_mem_wdata  output  DATA_W  memory write data.
- in_mem_rdata  input  DATA_W  memory read data.
- out_a_preempt  output  1  sticky flag: the A_MAX_WAIT override has fired at least once.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; last-winner pointer = B (so A wins the first tie); state IDLE; wait counter 0; response pipeline cleared.
- Request sampling:
  - Requests, addresses and data are sampled at each rising edge.
  - A port's request is ignored on the edge where that port's gnt is already high. This gives each port at most one issue every 2 cycles.
  - A request withdrawn before its grant is simply dropped, with no side effects.
- Issue:
  - On the winning edge, the winner's gnt, out_mem_en, out_mem_we (B only; 0 for A), out_mem_addr and out_mem_wdata are all registered in the same cycle.
  - At most one port is granted per cycle.
- States:
  - IDLE/RR (round-robin):
    - Both ports eligible → grant the port that is not the last winner, then update the pointer.
    - A single eligible port → grant it.
    - B granted with in_b_lock=1 → go to LOCKED_B.
  - LOCKED_B:
    - Only B is granted while in_b_lock stays high.
    - in_b_lock low → back to RR; A wins the next tie.
    - A pending and the wait counter reaches A_MAX_WAIT → grant A on that edge, set out_a_preempt, go to PREEMPT.
  - PREEMPT: lasts one cycle after the A grant. No grants are issued in this cycle. Then return to LOCKED_B if in_b_lock is high, otherwise to RR.
- Wait counter:
  - Increments on each edge where A is eligible but not granted.
  - Clears on an A grant or when in_a_req is low.
  - Saturates at A_MAX_WAIT.
- Read response path:
  - Timing: out_mem_en high in cycle C → in_mem_rdata sampled at the end of cycle C+MEM_LATENCY → owner's rvalid and rdata high during cycle C+MEM_LATENCY+1.
  - A MEM_LATENCY-deep owner/valid shift pipeline tracks which port each read belongs to.
  - Writes push no response.
  - rdata holds its last value between rvalid pulses.
- Reset mid-operation: in-flight reads are discarded, so no rvalid follows reset. The lock is released.
- Address and data are passed through unchanged; no arithmetic, no width conversion.

Test Plan:
- Reset, then A requests addr 0x0001 (mem[1]=0x5A), MEM_LATENCY=1 → out_a_gnt high in cycle 1; out_a_rvalid high with out_a_rdata=0x5A in cycle 3; out_mem_we=0 throughout.
- A and B both request reads continuously from reset → grants alternate A,B,A,B; the first grant goes to A; never two gnts in one cycle; each rvalid is routed to the correct port.
- B writes 0x33 to 0xAACC, then A reads 0xAACC → out_mem_we=1 only in B's issue cycle; A receives 0x33.
- B holds lock with back-to-back requests, A requests at cycle T, A_MAX_WAIT=6 → A granted exactly at edge T+6; out_a_preempt=1 and stays 1; B is granted again at T+8.
- MEM_LATENCY=3, four alternating reads → each rvalid arrives 4 cycles after its gnt, in issue order; no response is lost or duplicated.
- Assert in_reset while two reads are in flight → all outputs 0 immediately; no rvalid afterwards; the first post-reset tie goes to A.
